// File: rtl/tt_um_seq_multiplier_hhrb98.sv
// Byte-serial shift-add multiplier for the Tiny Tapeout slot, one partial product per clock.
// Define SEQMUL_SIGNED_EN to build signed mode (uio_in[2] at start) and the SIGN fix-up state.
module tt_um_seq_multiplier_hhrb98 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned NPROD  = 2 * NBYTES;
  localparam int unsigned PTRW   = (NPROD > 1) ? $clog2(NPROD) : 1;
  localparam int unsigned CNTW   = $clog2(WIDTH + 1);

`ifdef SEQMUL_SIGNED_EN
  typedef enum logic [1:0] {IDLE, BUSY, SIGN, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]        cmd;
  logic              rd_adv;
  logic [WIDTH-1:0]  a_load, b_load;
  logic              unused_ok;

  assign cmd    = uio_in[1:0];
  assign rd_adv = uio_in[3];

`ifdef SEQMUL_SIGNED_EN
  logic sgn_q, sgn_d;
  logic start_signed;
  assign start_signed = uio_in[2];
  // Signed mode multiplies magnitudes; -2^(WIDTH-1) stays exact as an unsigned magnitude.
  assign a_load    = (start_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_load    = (start_signed && b_q[WIDTH-1]) ? -b_q : b_q;
  assign unused_ok = &{1'b0, uio_in[7:4]};
`else
  assign a_load    = a_q;
  assign b_load    = b_q;
  assign unused_ok = &{1'b0, uio_in[7:4], uio_in[2]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
`ifdef SEQMUL_SIGNED_EN
      sgn_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
`ifdef SEQMUL_SIGNED_EN
      sgn_q    <= sgn_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
`ifdef SEQMUL_SIGNED_EN
    sgn_d    = sgn_q;
`endif
    if (ena) begin
      case (state_q)
        IDLE, DONE: begin
          if (rd_adv) begin
            rd_ptr_d = (rd_ptr_q == PTRW'(NPROD - 1)) ? '0 : rd_ptr_q + PTRW'(1);
          end
          case (cmd)
            2'b01: a_d = (a_q << 8) | WIDTH'(ui_in);
            2'b10: b_d = (b_q << 8) | WIDTH'(ui_in);
            2'b11: begin
`ifdef SEQMUL_SIGNED_EN
              sgn_d    = start_signed;
`endif
              mcand_d  = PW'(a_load);
              mplier_d = b_load;
              acc_d    = '0;
              cnt_d    = '0;
              rd_ptr_d = '0;
              state_d  = BUSY;
            end
            default: ;
          endcase
        end
        BUSY: begin
          // The edge that finds cnt==WIDTH only hands over, giving WIDTH+1 busy cycles.
          if (cnt_q == CNTW'(WIDTH)) begin
`ifdef SEQMUL_SIGNED_EN
            state_d = sgn_q ? SIGN : DONE;
`else
            state_d = DONE;
`endif
          end else begin
            if (mplier_q[0]) begin
              acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNTW'(1);
          end
        end
`ifdef SEQMUL_SIGNED_EN
        SIGN: begin
          if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) begin
            acc_d = -acc_q;
          end
          state_d = DONE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    uo_out = '0;
    for (int unsigned i = 0; i < NPROD; i++) begin
      if (rd_ptr_q == PTRW'(i)) begin
        uo_out = acc_q[8*i +: 8];
      end
    end
    uio_out = '0;
`ifdef SEQMUL_SIGNED_EN
    uio_out[7] = (state_q == BUSY) || (state_q == SIGN);
`else
    uio_out[7] = (state_q == BUSY);
`endif
    uio_out[6] = (state_q == DONE);
    uio_oe     = 8'b1100_0000;
  end

endmodule

// File: tb/tb_tt_um_seq_multiplier_hhrb98.sv
// Directed bench for tt_um_seq_multiplier_hhrb98 at WIDTH=8 and WIDTH=16.
// Signed-mode expectations are selected by SEQMUL_SIGNED_EN.
module tb_tt_um_seq_multiplier_hhrb98;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui8, uio8, ui16, uio16;
  logic [7:0] uo8, uiout8, oe8, uo16, uiout16, oe16;

  int total = 0;
  int bad   = 0;
  int gap   = 0;
  int ovl   = 0;
  int n;

  localparam logic [7:0] NOP = 8'h00, PA = 8'h01, PB = 8'h02, ST = 8'h03;
  localparam logic [7:0] SST = 8'h07, ADV = 8'h08;

  always #5 clk = ~clk;

  tt_um_seq_multiplier_hhrb98 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui8), .uio_in(uio8),
    .uo_out(uo8), .uio_out(uiout8), .uio_oe(oe8)
  );

  tt_um_seq_multiplier_hhrb98 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui16), .uio_in(uio16),
    .uo_out(uo16), .uio_out(uiout16), .uio_oe(oe16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd8(input logic [7:0] u, input logic [7:0] d);
    uio8 = u;
    ui8  = d;
    @(negedge clk);
    uio8 = '0;
    ui8  = '0;
  endtask

  task automatic cmd16(input logic [7:0] u, input logic [7:0] d);
    uio16 = u;
    ui16  = d;
    @(negedge clk);
    uio16 = '0;
    ui16  = '0;
  endtask

  // Counts active edges until done, noting any cycle without busy or with busy&done.
  task automatic wait_done(input bit sel16, output int cycles);
    logic [7:0] st;
    cycles = 0;
    gap    = 0;
    st = sel16 ? uiout16 : uiout8;
    while (st[6] !== 1'b1 && cycles < 100) begin
      if (st[7] !== 1'b1) gap++;
      @(negedge clk);
      cycles++;
      st = sel16 ? uiout16 : uiout8;
      if (st[7] === 1'b1 && st[6] === 1'b1) ovl++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    ui8 = '0; uio8 = '0; ui16 = '0; uio16 = '0;
    #12;
    chk("reset_uo", {24'd0, uo8}, 32'h00);
    chk("reset_uio_out", {24'd0, uiout8}, 32'h00);
    chk("reset_oe8", {24'd0, oe8}, 32'hC0);
    chk("reset_oe16", {24'd0, oe16}, 32'hC0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xFF * 0xFF = 0xFE01
    cmd8(PA, 8'hFF);
    cmd8(PB, 8'hFF);
    cmd8(ST, 8'h00);
    chk("ff_busy_at_T", {24'd0, uiout8}, 32'h80);
    wait_done(1'b0, n);
    chk("ff_latency", n, 9);
    chk("ff_busy_gap", gap, 0);
    chk("ff_status_done", {24'd0, uiout8}, 32'h40);
    chk("ff_byte0", {24'd0, uo8}, 32'h01);
    cmd8(ADV, 8'h00);
    chk("ff_byte1", {24'd0, uo8}, 32'hFE);
    cmd8(ADV, 8'h00);
    chk("ff_wrap", {24'd0, uo8}, 32'h01);

    // 0xFD * 0x05 with the signed bit set at start
    cmd8(PA, 8'hFD);
    cmd8(PB, 8'h05);
    cmd8(SST, 8'h00);
    wait_done(1'b0, n);
    chk("m3x5_busy_gap", gap, 0);
`ifdef SEQMUL_SIGNED_EN
    chk("m3x5_latency", n, 10);
    chk("m3x5_byte0", {24'd0, uo8}, 32'hF1);
    cmd8(ADV, 8'h00);
    chk("m3x5_byte1", {24'd0, uo8}, 32'hFF);
`else
    chk("m3x5_latency", n, 9);
    chk("m3x5_byte0", {24'd0, uo8}, 32'hF1);
    cmd8(ADV, 8'h00);
    chk("m3x5_byte1", {24'd0, uo8}, 32'h04);
`endif

    // 0x80 * 0x80 = 0x4000 both signed and unsigned
    cmd8(PA, 8'h80);
    cmd8(PB, 8'h80);
    cmd8(SST, 8'h00);
    wait_done(1'b0, n);
`ifdef SEQMUL_SIGNED_EN
    chk("m128_latency", n, 10);
`else
    chk("m128_latency", n, 9);
`endif
    chk("m128_byte0", {24'd0, uo8}, 32'h00);
    cmd8(ADV, 8'h00);
    chk("m128_byte1", {24'd0, uo8}, 32'h40);

    // zero operands still run the full length
    cmd8(PA, 8'h00);
    cmd8(PB, 8'h00);
    cmd8(ST, 8'h00);
    wait_done(1'b0, n);
    chk("zero_latency", n, 9);
    chk("zero_byte0", {24'd0, uo8}, 32'h00);
    cmd8(ADV, 8'h00);
    chk("zero_byte1", {24'd0, uo8}, 32'h00);

    // 0x0D * 0x0B = 0x8F, with push/start/advance issued while busy
    cmd8(PA, 8'h0D);
    cmd8(PB, 8'h0B);
    cmd8(ST, 8'h00);
    cmd8(PA, 8'hAA);
    cmd8(ST, 8'h00);
    cmd8(ADV, 8'h00);
    wait_done(1'b0, n);
    chk("busycmd_latency", n + 3, 9);
    chk("busycmd_busy_gap", gap, 0);
    chk("busycmd_byte0", {24'd0, uo8}, 32'h8F);
    cmd8(ST, 8'h00);
    wait_done(1'b0, n);
    chk("busycmd_rerun_latency", n, 9);
    chk("busycmd_rerun_byte0", {24'd0, uo8}, 32'h8F);

    // reset partway through BUSY
    cmd8(ST, 8'h00);
    cmd8(NOP, 8'h00);
    cmd8(NOP, 8'h00);
    cmd8(NOP, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_uo", {24'd0, uo8}, 32'h00);
    chk("midrst_uio_out", {24'd0, uiout8}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle", {24'd0, uiout8}, 32'h00);
    cmd8(PA, 8'h07);
    cmd8(PB, 8'h09);
    cmd8(ST, 8'h00);
    wait_done(1'b0, n);
    chk("postrst_latency", n, 9);
    chk("postrst_byte0", {24'd0, uo8}, 32'h3F);

    // 0xC8 * 0x3B = 0x2E18 with ena low for 5 cycles mid-BUSY
    cmd8(PA, 8'hC8);
    cmd8(PB, 8'h3B);
    cmd8(ST, 8'h00);
    cmd8(NOP, 8'h00);
    cmd8(NOP, 8'h00);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    chk("ena_busy_held", {24'd0, uiout8}, 32'h80);
    ena = 1'b1;
    wait_done(1'b0, n);
    chk("ena_latency", n + 7, 14);
    chk("ena_byte0", {24'd0, uo8}, 32'h18);
    cmd8(ADV, 8'h00);
    chk("ena_byte1", {24'd0, uo8}, 32'h2E);

    // WIDTH=16: 0x1234 * 0x5678 = 0x06260060
    cmd16(PA, 8'h12);
    cmd16(PA, 8'h34);
    cmd16(PB, 8'h56);
    cmd16(PB, 8'h78);
    cmd16(ST, 8'h00);
    wait_done(1'b1, n);
    chk("w16_latency", n, 17);
    chk("w16_busy_gap", gap, 0);
    chk("w16_byte0", {24'd0, uo16}, 32'h60);
    cmd16(ADV, 8'h00);
    chk("w16_byte1", {24'd0, uo16}, 32'h00);
    cmd16(ADV, 8'h00);
    chk("w16_byte2", {24'd0, uo16}, 32'h26);
    cmd16(ADV, 8'h00);
    chk("w16_byte3", {24'd0, uo16}, 32'h06);
    cmd16(ADV, 8'h00);
    chk("w16_wrap", {24'd0, uo16}, 32'h60);

    chk("busy_done_overlap", ovl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
